adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
Sequences one scan of the analog front end: steps the 3-bit analog mux through the enabled channels and waits a programmable settle time on each. It then requests one conversion from the ADC SPI reader and forwards the tagged result over a valid/ready stream. It sits between the acquisition control logic (start, mask, settle time) and the ADC reader.

Parameters:
DATA_W, 16, width of the ADC result word.
SETTLE_W, 8, width of the settle-time counter and input.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a scan when idle.
chn_mask  in  8  per-channel enable, bit i = mux channel i; sampled at start.
settle_cycles  in  SETTLE_W  mux settle wait in clk cycles; sampled at start.
analog_mux_chn  out  3  analog mux select.
conv_start  out  1  one-cycle pulse to the ADC reader.
conv_done  in  1  one-cycle pulse from the ADC reader; conv_data valid in the same cycle.
conv_data  in  DATA_W  conversion result.
res_valid  out  1  result available.
res_ready  in  1  downstream accepts the result.
res_data  out  DATA_W  held result.
res_chn  out  3  channel the result belongs to.
busy  out  1  high from the cycle after start until scan_done.
scan_done  out  1  one-cycle pulse at end of scan.
overrun  out  1  sticky; set when start arrives while busy. Cleared only by rst.

Behaviour:
- Reset (async, takes effect immediately): state IDLE. analog_mux_chn=0, conv_start=0, res_valid=0, res_data=0, res_chn=0, busy=0, scan_done=0, overrun=0.
- All outputs are registered. The state machine has a one-hot or binary state register plus comb next-state logic.
- States:
  - IDLE: on start, latch the mask and settle value and go to FIND.
    - If the latched mask is 0, go directly to DONE.
  - FIND: select the lowest enabled channel at or above the current index and drive it on analog_mux_chn. Load the settle counter with the latched settle value, then go to SETTLE. No enabled channel remaining -> DONE. FIND takes 1 cycle.
  - SETTLE: decrement the counter each cycle. When it equals 0, go to CONV. A settle value of 0 gives 0 wait cycles.
  - CONV: assert conv_start for exactly 1 cycle, then go to WAIT.
  - WAIT: hold analog_mux_chn stable. On conv_done, capture conv_data into res_data and the current channel into res_chn, set res_valid, and go to OUT.
  - OUT: hold res_valid/res_data/res_chn stable until res_valid&&res_ready. In that cycle clear res_valid, advance the index to channel+1, and go to FIND.
    - If the channel was 7, go to DONE instead (no wrap).
  - DONE: pulse scan_done for 1 cycle, clear busy, go to IDLE.
- Start while busy is ignored and sets overrun. Start in the same cycle as scan_done is also treated as busy.
- conv_done outside WAIT is ignored.
- The mux changes only in FIND. It never changes while WAIT or OUT is pending.
- Throughput per enabled channel: 1 (FIND) + S (settle) + 1 (CONV) + ADC latency + 1 cycle (capture) + handshake wait.
- rst mid-scan aborts immediately. No scan_done is produced, and no partial result remains.

Test Plan:
1. rst, then start with mask=8'h01, settle=3. Expect: mux=0; conv_start exactly 4 cycles after FIND; bench conv_done with 16'hABCD, res_ready=1; then res_data=16'hABCD, res_chn=0, a single scan_done, busy low after.
2. mask=8'hA5, settle=0, ADC returns 16'h1000+chn. Expect results in order chn 0,2,5,7 with matching data, 4 conv_start pulses total, scan_done after chn 7.
3. Backpressure: mask=8'h03, hold res_ready=0 for 10 cycles after the first result. Expect res_valid/res_data/res_chn stable, mux stays 0, no second conv_start until the handshake.
4. mask=8'h00 with start. Expect no conv_start, scan_done 2 cycles after start (FIND skipped, DONE), mux unchanged at 0.
5. A second start pulse during a scan with mask=8'hFF. Expect overrun=1 and sticky; the scan still completes 8 results; a later start while idle runs normally with overrun still 1.
6. Assert rst during WAIT on chn 3. Expect all outputs at reset values in the same cycle (async), state IDLE; a late conv_done is ignored; a new start works.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer: steps the analog mux over enabled channels, waits the settle time,
// triggers one ADC conversion per channel and presents each tagged result on a valid/ready stream.
module adc_scan_sequencer #(
  parameter int DATA_W   = 16,
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          chn_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [2:0]          analog_mux_chn,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [DATA_W-1:0]   conv_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic [2:0]          res_chn,
  output logic                busy,
  output logic                scan_done,
  output logic                overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_FIND, S_SETTLE, S_CONV, S_WAIT, S_OUT, S_DONE
  } state_t;

  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_ZERO = '0;

  state_t              state_q, state_d;
  logic [7:0]          mask_q, mask_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          mux_q, mux_d;
  logic                conv_start_q, conv_start_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [2:0]          res_chn_q, res_chn_d;
  logic                busy_q, busy_d;
  logic                scan_done_q, scan_done_d;
  logic                overrun_q, overrun_d;
  logic [3:0]          nxt;

  // Returns {found, channel}: lowest enabled channel at or above 'from'.
  function automatic logic [3:0] find_next(input logic [7:0] mask, input logic [2:0] from);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign nxt = find_next(mask_q, idx_q);

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    settle_d     = settle_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    mux_d        = mux_q;
    conv_start_d = 1'b0;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_chn_d    = res_chn_q;
    busy_d       = busy_q;
    scan_done_d  = 1'b0;
    overrun_d    = overrun_q;

    // The scan_done cycle is already IDLE but still counts as busy for a new start.
    if (start && ((state_q != S_IDLE) || scan_done_q)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && !scan_done_q) begin
          mask_d   = chn_mask;
          settle_d = settle_cycles;
          idx_d    = 3'd0;
          busy_d   = 1'b1;
          state_d  = (chn_mask == 8'd0) ? S_DONE : S_FIND;
        end
      end
      S_FIND: begin
        if (nxt[3]) begin
          mux_d = nxt[2:0];
          cnt_d = settle_q;
          if (settle_q == SETTLE_ZERO) begin
            conv_start_d = 1'b1;
            state_d      = S_CONV;
          end else begin
            state_d = S_SETTLE;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - SETTLE_ONE;
        if (cnt_q == SETTLE_ONE) begin
          conv_start_d = 1'b1;
          state_d      = S_CONV;
        end
      end
      S_CONV: state_d = S_WAIT;
      S_WAIT: begin
        if (conv_done) begin
          res_data_d  = conv_data;
          res_chn_d   = mux_q;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (mux_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            idx_d   = mux_q + 3'd1;
            state_d = S_FIND;
          end
        end
      end
      S_DONE: begin
        scan_done_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      settle_q     <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      mux_q        <= '0;
      conv_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_chn_q    <= '0;
      busy_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      mux_q        <= mux_d;
      conv_start_q <= conv_start_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_chn_q    <= res_chn_d;
      busy_q       <= busy_d;
      scan_done_q  <= scan_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign analog_mux_chn = mux_q;
  assign conv_start     = conv_start_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_chn        = res_chn_q;
  assign busy           = busy_q;
  assign scan_done      = scan_done_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural ADC reader and result log.
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  chn_mask = '0;
  logic [7:0]  settle_cycles = '0;
  logic [2:0]  analog_mux_chn;
  logic        conv_start;
  logic        conv_done = 1'b0;
  logic [15:0] conv_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_data;
  logic [2:0]  res_chn;
  logic        busy;
  logic        scan_done;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  logic        adc_en = 1'b1;
  int          adc_lat = 3;
  logic [15:0] adc_base = 16'h0000;

  int          n_conv = 0;
  int          n_done = 0;
  logic [2:0]  log_chn[$];
  logic [15:0] log_data[$];

  adc_scan_sequencer #(.DATA_W(16), .SETTLE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .chn_mask(chn_mask),
    .settle_cycles(settle_cycles), .analog_mux_chn(analog_mux_chn),
    .conv_start(conv_start), .conv_done(conv_done), .conv_data(conv_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_chn(res_chn), .busy(busy), .scan_done(scan_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ADC reader model: answers conv_start after adc_lat cycles with base + channel.
  always begin
    @(posedge clk); #2;
    if (adc_en && conv_start) begin
      for (int k = 0; k < adc_lat; k++) begin
        @(posedge clk); #2;
      end
      conv_done = 1'b1;
      conv_data = adc_base + 16'(analog_mux_chn);
      @(posedge clk); #2;
      conv_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (conv_start) n_conv++;
    if (scan_done) n_done++;
    if (res_valid && res_ready) begin
      log_chn.push_back(res_chn);
      log_data.push_back(res_data);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] m, input logic [7:0] s);
    start = 1'b1; chn_mask = m; settle_cycles = s;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k;
    ok = 1'b0; k = 0;
    while (!ok && k < budget) begin
      tick();
      k++;
      if (scan_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (analog_mux_chn !== 3'd0) begin failures++; $display("FAIL rst_mux got=%0d exp=0", analog_mux_chn); end
    checks++; if (conv_start !== 1'b0) begin failures++; $display("FAIL rst_conv_start got=%b exp=0", conv_start); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_data !== 16'h0) begin failures++; $display("FAIL rst_res_data got=%h exp=0", res_data); end
    checks++; if (res_chn !== 3'd0) begin failures++; $display("FAIL rst_res_chn got=%0d exp=0", res_chn); end
    checks++; if ({busy, scan_done, overrun} !== 3'b000) begin failures++; $display("FAIL rst_status got=%b exp=000", {busy, scan_done, overrun}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int base_conv, base_done, base_res, k;
    bit ok;
    res_ready = 1'b1; adc_lat = 3; adc_base = 16'hABCD;
    base_conv = n_conv; base_done = n_done; base_res = log_chn.size();
    do_start(8'h01, 8'd3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    k = 0;
    while (k < 20 && conv_start !== 1'b1) begin tick(); k++; end
    checks++; if (k != 4) begin failures++; $display("FAIL single_conv_latency got=%0d exp=4", k); end
    checks++; if (analog_mux_chn !== 3'd0) begin failures++; $display("FAIL single_mux got=%0d exp=0", analog_mux_chn); end
    wait_done(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_done_timeout got=0 exp=1"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    tick();
    checks++; if (n_done - base_done != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", n_done - base_done); end
    checks++; if (n_conv - base_conv != 1) begin failures++; $display("FAIL single_conv_count got=%0d exp=1", n_conv - base_conv); end
    checks++; if (log_chn.size() - base_res != 1) begin failures++; $display("FAIL single_res_count got=%0d exp=1", log_chn.size() - base_res); end
    else begin
      checks++; if (log_data[base_res] !== 16'hABCD) begin failures++; $display("FAIL single_res_data got=%h exp=abcd", log_data[base_res]); end
      checks++; if (log_chn[base_res] !== 3'd0) begin failures++; $display("FAIL single_res_chn got=%0d exp=0", log_chn[base_res]); end
    end
  endtask

  task automatic test_empty_mask();
    int base_conv;
    base_conv = n_conv;
    do_start(8'h00, 8'd5);
    checks++; if (scan_done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL empty_first got=%b%b exp=01", scan_done, busy); end
    tick();
    checks++; if (scan_done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL empty_done got=%b%b exp=10", scan_done, busy); end
    tick();
    checks++; if (scan_done !== 1'b0) begin failures++; $display("FAIL empty_pulse got=%b exp=0", scan_done); end
    checks++; if (analog_mux_chn !== 3'd0) begin failures++; $display("FAIL empty_mux got=%0d exp=0", analog_mux_chn); end
    checks++; if (n_conv != base_conv) begin failures++; $display("FAIL empty_conv got=%0d exp=%0d", n_conv, base_conv); end
  endtask

  task automatic test_multi();
    int base_conv, base_res;
    bit ok;
    logic [2:0] exp_chn[4];
    exp_chn[0] = 3'd0; exp_chn[1] = 3'd2; exp_chn[2] = 3'd5; exp_chn[3] = 3'd7;
    adc_lat = 2; adc_base = 16'h1000; res_ready = 1'b1;
    base_conv = n_conv; base_res = log_chn.size();
    do_start(8'hA5, 8'd0);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL multi_done_timeout got=0 exp=1"); end
    checks++; if (n_conv - base_conv != 4) begin failures++; $display("FAIL multi_conv_count got=%0d exp=4", n_conv - base_conv); end
    checks++; if (log_chn.size() - base_res != 4) begin failures++; $display("FAIL multi_res_count got=%0d exp=4", log_chn.size() - base_res); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (log_chn[base_res+i] !== exp_chn[i]) begin failures++; $display("FAIL multi_chn[%0d] got=%0d exp=%0d", i, log_chn[base_res+i], exp_chn[i]); end
        checks++; if (log_data[base_res+i] !== 16'h1000 + 16'(exp_chn[i])) begin failures++; $display("FAIL multi_data[%0d] got=%h exp=%h", i, log_data[base_res+i], 16'h1000 + 16'(exp_chn[i])); end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int base_conv, base_res, k;
    bit ok;
    adc_lat = 2; adc_base = 16'h3300; res_ready = 1'b0;
    base_conv = n_conv; base_res = log_chn.size();
    do_start(8'h03, 8'd1);
    k = 0;
    while (k < 40 && res_valid !== 1'b1) begin tick(); k++; end
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout got=%b exp=1", res_valid); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'h3300 || res_chn !== 3'd0 || analog_mux_chn !== 3'd0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=v%b d%h c%0d m%0d exp=v1 d3300 c0 m0", i, res_valid, res_data, res_chn, analog_mux_chn);
      end
    end
    checks++; if (n_conv - base_conv != 1) begin failures++; $display("FAIL bp_conv_hold got=%0d exp=1", n_conv - base_conv); end
    res_ready = 1'b1;
    wait_done(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    checks++; if (n_conv - base_conv != 2) begin failures++; $display("FAIL bp_conv_count got=%0d exp=2", n_conv - base_conv); end
    checks++; if (log_chn.size() - base_res != 2) begin failures++; $display("FAIL bp_res_count got=%0d exp=2", log_chn.size() - base_res); end
    else begin
      checks++; if (log_chn[base_res+1] !== 3'd1 || log_data[base_res+1] !== 16'h3301) begin failures++; $display("FAIL bp_second got=c%0d d%h exp=c1 d3301", log_chn[base_res+1], log_data[base_res+1]); end
    end
    tick();
  endtask

  task automatic test_overrun();
    int base_res;
    bit ok;
    adc_lat = 1; adc_base = 16'h2000; res_ready = 1'b1;
    base_res = log_chn.size();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_initial got=%b exp=0", overrun); end
    do_start(8'hFF, 8'd0);
    repeat (3) tick();
    do_start(8'h01, 8'd4);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    wait_done(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovr_done_timeout got=0 exp=1"); end
    checks++; if (log_chn.size() - base_res != 8) begin failures++; $display("FAIL ovr_res_count got=%0d exp=8", log_chn.size() - base_res); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (log_chn[base_res+i] !== 3'(i) || log_data[base_res+i] !== 16'h2000 + 16'(i)) begin failures++; $display("FAIL ovr_res[%0d] got=c%0d d%h exp=c%0d d%h", i, log_chn[base_res+i], log_data[base_res+i], i, 16'h2000 + 16'(i)); end
      end
    end
    tick(); tick();
    base_res = log_chn.size();
    do_start(8'h10, 8'd0);
    wait_done(60, ok);
    checks++; if (!ok || log_chn.size() - base_res != 1) begin failures++; $display("FAIL ovr_rerun got=ok%0d n%0d exp=ok1 n1", ok, log_chn.size() - base_res); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    tick();
  endtask

  task automatic test_abort();
    int base_res, base_done, k;
    bit ok;
    adc_lat = 5; adc_base = 16'h5500; res_ready = 1'b1;
    base_res = log_chn.size(); base_done = n_done;
    do_start(8'h08, 8'd2);
    k = 0;
    while (k < 20 && conv_start !== 1'b1) begin tick(); k++; end
    tick();
    checks++; if (analog_mux_chn !== 3'd3 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre got=m%0d b%b exp=m3 b1", analog_mux_chn, busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (analog_mux_chn !== 3'd0 || conv_start !== 1'b0 || res_valid !== 1'b0 || res_data !== 16'h0 ||
        res_chn !== 3'd0 || busy !== 1'b0 || scan_done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL abort_async got=m%0d v%b b%b o%b exp=m0 v0 b0 o0", analog_mux_chn, res_valid, busy, overrun);
    end
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    checks++; if (res_valid !== 1'b0 || log_chn.size() != base_res) begin failures++; $display("FAIL abort_late_done got=v%b n%0d exp=v0 n%0d", res_valid, log_chn.size(), base_res); end
    checks++; if (n_done != base_done) begin failures++; $display("FAIL abort_no_scan_done got=%0d exp=%0d", n_done, base_done); end
    adc_lat = 2;
    do_start(8'h02, 8'd0);
    wait_done(60, ok);
    checks++; if (!ok || log_chn.size() - base_res != 1) begin failures++; $display("FAIL abort_restart got=ok%0d n%0d exp=ok1 n1", ok, log_chn.size() - base_res); end
    else begin
      checks++; if (log_chn[base_res] !== 3'd1 || log_data[base_res] !== 16'h5501) begin failures++; $display("FAIL abort_restart_res got=c%0d d%h exp=c1 d5501", log_chn[base_res], log_data[base_res]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty_mask();
    test_multi();
    test_backpressure();
    test_overrun();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
